// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - execute-stage, MEM/WB and byte-RAM signals of the memory-access stage
interface mem_access_if;
  logic        ex_write;
  logic [4:0]  ex_write_address;
  logic [31:0] ex_write_data;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_address;
  logic [31:0] ex_store_data;
  logic        mem_write;
  logic [4:0]  mem_write_address;
  logic [31:0] mem_write_data;
  logic        stall_request;
  logic [31:0] ram_address;
  logic        ram_write_enable;
  logic [7:0]  ram_write_data;
  logic [7:0]  ram_read_data;

  modport slave (
    input  ex_write, ex_write_address, ex_write_data, ex_mem_op,
    input  ex_mem_address, ex_store_data, ram_read_data,
    output mem_write, mem_write_address, mem_write_data, stall_request,
    output ram_address, ram_write_enable, ram_write_data
  );

  modport master (
    output ex_write, ex_write_address, ex_write_data, ex_mem_op,
    output ex_mem_address, ex_store_data, ram_read_data,
    input  mem_write, mem_write_address, mem_write_data, stall_request,
    input  ram_address, ram_write_enable, ram_write_data
  );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline memory stage serialising loads/stores over a byte-wide RAM
module mem_access (
  input  logic         clock,
  input  logic         reset,
  mem_access_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] result_q, result_d;

  logic        is_load, is_store, sign_ext;
  logic [1:0]  n_m1;
  logic [1:0]  byte_idx;
  logic [1:0]  offset;
  logic [31:0] assembled;
  logic [31:0] extended;
  logic [7:0]  store_byte;

  logic        mem_write;
  logic [4:0]  mem_write_address;
  logic [31:0] mem_write_data;
  logic        stall_request;
  logic [31:0] ram_address;
  logic        ram_write_enable;
  logic [7:0]  ram_write_data;

  // n_m1 holds byte count minus one so a 2-bit value covers n = 1, 2, 4
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sign_ext = 1'b0;
    n_m1     = 2'd0;
    case (bus.ex_mem_op)
      4'd1: begin is_load = 1'b1;  sign_ext = 1'b1; n_m1 = 2'd0; end
      4'd2: begin is_load = 1'b1;  sign_ext = 1'b1; n_m1 = 2'd1; end
      4'd3: begin is_load = 1'b1;  n_m1 = 2'd3; end
      4'd4: begin is_load = 1'b1;  n_m1 = 2'd0; end
      4'd5: begin is_load = 1'b1;  n_m1 = 2'd1; end
      4'd6: begin is_store = 1'b1; n_m1 = 2'd0; end
      4'd7: begin is_store = 1'b1; n_m1 = 2'd1; end
      4'd8: begin is_store = 1'b1; n_m1 = 2'd3; end
      default: begin end
    endcase
  end

  // In LOAD the byte arriving now was addressed at offset k-1; for LW the
  // final k wraps to 0, which still maps onto byte 3.
  assign byte_idx = k_q - 2'd1;

  always_comb begin
    assembled = result_q;
    case (byte_idx)
      2'd0: assembled[7:0]   = bus.ram_read_data;
      2'd1: assembled[15:8]  = bus.ram_read_data;
      2'd2: assembled[23:16] = bus.ram_read_data;
      2'd3: assembled[31:24] = bus.ram_read_data;
      default: begin end
    endcase
  end

  always_comb begin
    extended = assembled;
    case (n_m1)
      2'd0: extended = {{24{sign_ext & assembled[7]}},  assembled[7:0]};
      2'd1: extended = {{16{sign_ext & assembled[15]}}, assembled[15:0]};
      default: extended = assembled;
    endcase
  end

  always_comb begin
    store_byte = bus.ex_store_data[7:0];
    case (k_q)
      2'd1: store_byte = bus.ex_store_data[15:8];
      2'd2: store_byte = bus.ex_store_data[23:16];
      2'd3: store_byte = bus.ex_store_data[31:24];
      default: store_byte = bus.ex_store_data[7:0];
    endcase
  end

  always_comb begin
    state_d           = state_q;
    k_d               = k_q;
    result_d          = result_q;
    mem_write         = 1'b0;
    mem_write_address = bus.ex_write_address;
    mem_write_data    = bus.ex_write_data;
    stall_request     = 1'b0;
    offset            = 2'd0;
    ram_write_enable  = 1'b0;
    ram_write_data    = 8'd0;

    case (state_q)
      IDLE: begin
        if (is_load) begin
          stall_request = 1'b1;
          state_d       = LOAD;
          k_d           = 2'd1;
        end else if (is_store) begin
          ram_write_enable = 1'b1;
          ram_write_data   = bus.ex_store_data[7:0];
          if (n_m1 != 2'd0) begin
            stall_request = 1'b1;
            state_d       = STORE;
            k_d           = 2'd1;
          end
        end else begin
          mem_write = bus.ex_write;
        end
      end
      LOAD: begin
        offset = k_q;
        if (byte_idx == n_m1) begin
          mem_write      = bus.ex_write;
          mem_write_data = extended;
          state_d        = IDLE;
          k_d            = 2'd0;
        end else begin
          stall_request = 1'b1;
          result_d      = assembled;
          k_d           = k_q + 2'd1;
        end
      end
      STORE: begin
        offset           = k_q;
        ram_write_enable = 1'b1;
        ram_write_data   = store_byte;
        if (k_q == n_m1) begin
          state_d = IDLE;
          k_d     = 2'd0;
        end else begin
          stall_request = 1'b1;
          k_d           = k_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = 2'd0;
      end
    endcase

    ram_address = bus.ex_mem_address + {30'd0, offset};

    // Held in reset, the stage presents an all-zero face to MEM/WB and the RAM
    if (!reset) begin
      mem_write         = 1'b0;
      mem_write_address = 5'd0;
      mem_write_data    = 32'd0;
      stall_request     = 1'b0;
      ram_address       = 32'd0;
      ram_write_enable  = 1'b0;
      ram_write_data    = 8'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      k_q      <= 2'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

  assign bus.mem_write         = mem_write;
  assign bus.mem_write_address = mem_write_address;
  assign bus.mem_write_data    = mem_write_data;
  assign bus.stall_request     = stall_request;
  assign bus.ram_address       = ram_address;
  assign bus.ram_write_enable  = ram_write_enable;
  assign bus.ram_write_data    = ram_write_data;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized bench for mem_access against a transaction-level model
module tb_mem_access;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic preload = 1'b1;

  always #5 clock = ~clock;

  mem_access_if intf();

  mem_access dut (
    .clock (clock),
    .reset (reset),
    .bus   (intf.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ram     [1024];
  logic [7:0] ref_mem [1024];

  // Test addresses live in 0x000..0x1FF and 0xFFFFFF00..0xFFFFFFFF
  function automatic logic [9:0] idx(input logic [31:0] a);
    return {a[31], a[8:0]};
  endfunction

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ram[i] <= ref_mem[i];
      intf.ram_read_data <= 8'h00;
    end else begin
      intf.ram_read_data <= ram[idx(intf.ram_address)];
      if (intf.ram_write_enable) ram[idx(intf.ram_address)] <= intf.ram_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < nbytes(op); i++)
      v = v + (32'(ref_mem[idx(addr + 32'(i))]) << (8 * i));
    if (op == 4'd1 && v >= 32'h80)   v = v - 32'h100;
    if (op == 4'd2 && v >= 32'h8000) v = v - 32'h10000;
    return v;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic wr, input logic [4:0] rd, input logic [31:0] wd);
    intf.ex_mem_op        = op;
    intf.ex_mem_address   = addr;
    intf.ex_store_data    = sd;
    intf.ex_write         = wr;
    intf.ex_write_address = rd;
    intf.ex_write_data    = wd;
  endtask

  // Called just after a rising edge; returns just after the edge ending the op
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sd, input logic wr, input logic [4:0] rd,
                       input logic [31:0] wd);
    int n;
    bit ld, st;
    int cycles;
    logic [31:0] expv;
    n  = nbytes(op);
    ld = (op >= 4'd1 && op <= 4'd5);
    st = (op >= 4'd6 && op <= 4'd8);
    expv = ref_load(op, addr);
    cycles = ld ? n + 1 : (st ? n : 1);
    drive(op, addr, sd, wr, rd, wd);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      if (!ld && !st) begin
        chk({tag, ".none_mw"},    32'(intf.mem_write), 32'(wr));
        chk({tag, ".none_rd"},    32'(intf.mem_write_address), 32'(rd));
        chk({tag, ".none_data"},  intf.mem_write_data, wd);
        chk({tag, ".none_stall"}, 32'(intf.stall_request), 32'd0);
        chk({tag, ".none_we"},    32'(intf.ram_write_enable), 32'd0);
        chk({tag, ".none_addr"},  intf.ram_address, addr);
      end else if (ld) begin
        chk({tag, ".ld_we"}, 32'(intf.ram_write_enable), 32'd0);
        if (c < n) begin
          chk({tag, ".ld_stall"}, 32'(intf.stall_request), 32'd1);
          chk({tag, ".ld_mw"},    32'(intf.mem_write), 32'd0);
          chk({tag, ".ld_addr"},  intf.ram_address, addr + 32'(c));
        end else begin
          chk({tag, ".ld_stall_end"}, 32'(intf.stall_request), 32'd0);
          chk({tag, ".ld_mw_end"},    32'(intf.mem_write), 32'(wr));
          chk({tag, ".ld_rd"},        32'(intf.mem_write_address), 32'(rd));
          chk({tag, ".ld_data"},      intf.mem_write_data, expv);
        end
      end else begin
        chk({tag, ".st_we"},    32'(intf.ram_write_enable), 32'd1);
        chk({tag, ".st_addr"},  intf.ram_address, addr + 32'(c));
        chk({tag, ".st_byte"},  32'(intf.ram_write_data), (sd >> (8 * c)) & 32'hFF);
        chk({tag, ".st_stall"}, 32'(intf.stall_request), (c < n - 1) ? 32'd1 : 32'd0);
        chk({tag, ".st_mw"},    32'(intf.mem_write), 32'd0);
        ref_mem[idx(addr + 32'(c))] = sd[8*c +: 8];
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mw"},    32'(intf.mem_write), 32'd0);
    chk({tag, ".rd"},    32'(intf.mem_write_address), 32'd0);
    chk({tag, ".data"},  intf.mem_write_data, 32'd0);
    chk({tag, ".stall"}, 32'(intf.stall_request), 32'd0);
    chk({tag, ".we"},    32'(intf.ram_write_enable), 32'd0);
    chk({tag, ".addr"},  intf.ram_address, 32'd0);
    chk({tag, ".wbyte"}, 32'(intf.ram_write_data), 32'd0);
  endtask

  initial begin
    logic [31:0] sd;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    ref_mem[idx(32'h100)] = 8'h78;
    ref_mem[idx(32'h101)] = 8'h56;
    ref_mem[idx(32'h102)] = 8'h34;
    ref_mem[idx(32'h103)] = 8'h12;
    ref_mem[idx(32'h7)]   = 8'h80;

    // Reset with a busy-looking store presented: outputs must stay zero
    drive(4'd8, 32'h120, 32'hDEADBEEF, 1'b1, 5'd9, 32'h55AA55AA);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_zero("reset");
    @(posedge clock);
    #1;
    preload = 1'b0;
    reset   = 1'b1;

    do_op("none_basic", 4'd0, 32'h40, 32'h0, 1'b1, 5'd5, 32'h1234);
    do_op("lw_0x100",   4'd3, 32'h100, 32'h0, 1'b1, 5'd3, 32'h0);
    chk("lw_0x100.model", ref_load(4'd3, 32'h100), 32'h12345678);
    do_op("lb_0x7",     4'd1, 32'h7, 32'h0, 1'b1, 5'd7, 32'h0);
    do_op("lbu_0x7",    4'd4, 32'h7, 32'h0, 1'b1, 5'd7, 32'h0);
    do_op("sh_wrap",    4'd7, 32'hFFFFFFFF, 32'hAABBCCDD, 1'b1, 5'd1, 32'h0);
    do_op("lhu_wrap",   4'd5, 32'hFFFFFFFF, 32'h0, 1'b1, 5'd2, 32'h0);
    do_op("sw_b2b",     4'd8, 32'h1F0, 32'hCAFEF00D, 1'b1, 5'd4, 32'h0);
    do_op("lhu_b2b",    4'd5, 32'h1F1, 32'h0, 1'b1, 5'd4, 32'h0);
    do_op("bad_op",     4'd12, 32'h33, 32'h0, 1'b1, 5'd30, 32'h0BADC0DE);

    // SW aborted by reset in its third cycle: only bytes 0 and 1 land
    sd = 32'h44332211;
    drive(4'd8, 32'h120, sd, 1'b1, 5'd6, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      chk("sw_abort.we", 32'(intf.ram_write_enable), 32'd1);
      chk("sw_abort.addr", intf.ram_address, 32'h120 + 32'(c));
      ref_mem[idx(32'h120 + 32'(c))] = sd[8*c +: 8];
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    @(negedge clock);
    chk_zero("sw_abort_rst");
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(4'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clock);
    chk("sw_abort_after.we",    32'(intf.ram_write_enable), 32'd0);
    chk("sw_abort_after.stall", 32'(intf.stall_request), 32'd0);
    chk("sw_abort_after.mw",    32'(intf.mem_write), 32'd0);
    @(posedge clock);
    #1;
    do_op("lb_after_abort", 4'd1, 32'h122, 32'h0, 1'b1, 5'd8, 32'h0);
    do_op("lw_after_abort", 4'd3, 32'h120, 32'h0, 1'b1, 5'd8, 32'h0);

    for (int t = 0; t < 300; t++) begin
      logic [31:0] addr;
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      else                           addr = 32'($urandom_range(0, 500));
      do_op($sformatf("rnd%0d", t), 4'($urandom_range(0, 15)), addr, $urandom,
            1'($urandom), 5'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
